// File: rtl/vld_symbol_controller_pkg.sv
// Shared state encoding and width helper for the variable-length symbol controller.
package vld_symbol_controller_pkg;

    typedef enum logic [1:0] {
        StRun,
        StAlign,
        StErr
    } vld_state_e;

    // Bits needed to hold any value in 0..x (a full buffer reports x itself).
    function automatic int unsigned log2(input int unsigned x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/vld_header_decode.sv
// Combinational decode of the length-prefixed symbol at the head of the bit buffer.
module vld_header_decode #(
    parameter int unsigned WIDTH_OUT = 8,
    parameter int unsigned LEN_W     = 3,
    parameter int unsigned MAX_PAY   = 4,
    parameter int unsigned SIZE_W    = 5,
    parameter int unsigned NEED_W    = 4
) (
    input  logic [WIDTH_OUT-1:0] buf_q,
    input  logic [SIZE_W-1:0]    buf_size,
    output logic [LEN_W-1:0]     n,
    output logic [NEED_W-1:0]    need,
    output logic [MAX_PAY-1:0]   payload,
    output logic                 ok,
    output logic                 bad
);

    logic [MAX_PAY-1:0] pay_mask;
    logic               unused_bits;

    // Peek bits above the widest legal symbol never influence the decode.
    assign unused_bits = ^buf_q[WIDTH_OUT-1:LEN_W+MAX_PAY];

    always_comb begin
        n        = buf_q[LEN_W-1:0];
        need     = NEED_W'(LEN_W) + NEED_W'(n);
        pay_mask = MAX_PAY'((32'd1 << n) - 32'd1);
        payload  = buf_q[LEN_W +: MAX_PAY] & pay_mask;
        ok       = (32'(buf_size) >= 32'(need)) && (32'(n) <= MAX_PAY);
        bad      = (32'(buf_size) >= LEN_W) && (32'(n) > MAX_PAY);
    end

endmodule

// File: rtl/vld_symbol_controller.sv
// Push/pop sequencer for the variable-length bit buffer: admits words, parses
// length-prefixed symbols into a one-deep output slot, and services align requests.
module vld_symbol_controller
    import vld_symbol_controller_pkg::*;
#(
    parameter int unsigned WIDTH_IN     = 8,
    parameter int unsigned WIDTH_OUT    = 8,
    parameter int unsigned BUFFER_WIDTH = 16,
    parameter int unsigned LEN_W        = 3,
    parameter int unsigned MAX_PAY      = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH_IN-1:0]           in_data,
    output logic                          buf_push,
    output logic [WIDTH_IN-1:0]           buf_d,
    input  logic                          buf_full,
    input  logic [log2(BUFFER_WIDTH)-1:0] buf_size,
    output logic [log2(WIDTH_OUT)-1:0]    buf_pop,
    input  logic [WIDTH_OUT-1:0]          buf_q,
    input  logic                          align,
    output logic                          sym_valid,
    input  logic                          sym_ready,
    output logic [LEN_W-1:0]              sym_len,
    output logic [MAX_PAY-1:0]            sym_data,
    output logic                          err,
    output logic [CNT_W-1:0]              sym_count,
    output logic [CNT_W-1:0]              bit_count
);

    localparam int unsigned SIZE_W = log2(BUFFER_WIDTH);
    localparam int unsigned POP_W  = log2(WIDTH_OUT);
    localparam int unsigned NEED_W = log2(LEN_W + (1 << LEN_W) - 1);

    vld_state_e           state_q, state_d;
    logic                 align_pend_q, align_pend_d;
    logic                 sym_valid_q, sym_valid_d;
    logic [LEN_W-1:0]     sym_len_q, sym_len_d;
    logic [MAX_PAY-1:0]   sym_data_q, sym_data_d;
    logic [CNT_W-1:0]     sym_count_q, bit_count_q;

    logic [LEN_W-1:0]     hdr_n;
    logic [NEED_W-1:0]    hdr_need;
    logic [MAX_PAY-1:0]   hdr_payload;
    logic                 hdr_ok, hdr_bad;

    logic                 slot_free, load;
    logic [POP_W-1:0]     pop;
    logic [CNT_W-1:0]     phase, remain, align_lim;

    vld_header_decode #(
        .WIDTH_OUT (WIDTH_OUT),
        .LEN_W     (LEN_W),
        .MAX_PAY   (MAX_PAY),
        .SIZE_W    (SIZE_W),
        .NEED_W    (NEED_W)
    ) u_decode (
        .buf_q    (buf_q),
        .buf_size (buf_size),
        .n        (hdr_n),
        .need     (hdr_need),
        .payload  (hdr_payload),
        .ok       (hdr_ok),
        .bad      (hdr_bad)
    );

    assign in_ready  = !buf_full;
    assign buf_push  = in_valid & in_ready;
    assign buf_d     = in_data;
    assign slot_free = !sym_valid_q | sym_ready;

    // Distance to the next word boundary of the consumed bitstream, capped per cycle.
    always_comb begin
        phase     = bit_count_q % CNT_W'(WIDTH_IN);
        remain    = (phase == '0) ? '0 : CNT_W'(WIDTH_IN) - phase;
        align_lim = remain;
        if (align_lim > CNT_W'(WIDTH_OUT - 1)) align_lim = CNT_W'(WIDTH_OUT - 1);
        if (align_lim > CNT_W'(buf_size))      align_lim = CNT_W'(buf_size);
    end

    always_comb begin
        state_d      = state_q;
        align_pend_d = align_pend_q;
        load         = 1'b0;
        pop          = '0;
        unique case (state_q)
            StRun: begin
                if (slot_free && hdr_ok) begin
                    load         = 1'b1;
                    pop          = POP_W'(hdr_need);
                    align_pend_d = align_pend_q | align;
                end else if (hdr_bad) begin
                    state_d      = StErr;
                    align_pend_d = 1'b0;
                end else if (align_pend_q) begin
                    state_d      = StAlign;
                    align_pend_d = 1'b0;
                end else begin
                    align_pend_d = align;
                end
            end
            StAlign: begin
                align_pend_d = 1'b0;
                if (remain == '0) state_d = StRun;
                else              pop     = POP_W'(align_lim);
            end
            StErr: begin
                align_pend_d = 1'b0;
            end
            default: begin
                state_d      = StRun;
                align_pend_d = 1'b0;
            end
        endcase

        sym_valid_d = load | (sym_valid_q & !sym_ready);
        sym_len_d   = load ? hdr_n : sym_len_q;
        sym_data_d  = load ? hdr_payload : sym_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            align_pend_q <= 1'b0;
            sym_valid_q  <= 1'b0;
            sym_len_q    <= '0;
            sym_data_q   <= '0;
            sym_count_q  <= '0;
            bit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            align_pend_q <= align_pend_d;
            sym_valid_q  <= sym_valid_d;
            sym_len_q    <= sym_len_d;
            sym_data_q   <= sym_data_d;
            sym_count_q  <= sym_count_q + CNT_W'(sym_valid_q & sym_ready);
            bit_count_q  <= bit_count_q + CNT_W'(pop);
        end
    end

    assign buf_pop   = rst ? '0 : pop;
    assign sym_valid = sym_valid_q;
    assign sym_len   = sym_len_q;
    assign sym_data  = sym_data_q;
    assign err       = (state_q == StErr);
    assign sym_count = sym_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_vld_symbol_controller.sv
// Bench for vld_symbol_controller with a behavioural bit buffer in the loop.
module tb_vld_symbol_controller;

    logic        clk, rst, in_valid, in_ready, buf_push, buf_full, align;
    logic        sym_valid, sym_ready, err;
    logic [7:0]  in_data, buf_d, buf_q;
    logic [4:0]  buf_size;
    logic [3:0]  buf_pop;
    logic [2:0]  sym_len;
    logic [3:0]  sym_data;
    logic [15:0] sym_count, bit_count;

    int tests_run = 0;
    int tests_failed = 0;

    vld_symbol_controller #(
        .WIDTH_IN     (8),
        .WIDTH_OUT    (8),
        .BUFFER_WIDTH (16),
        .LEN_W        (3),
        .MAX_PAY      (4),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .buf_push  (buf_push),
        .buf_d     (buf_d),
        .buf_full  (buf_full),
        .buf_size  (buf_size),
        .buf_pop   (buf_pop),
        .buf_q     (buf_q),
        .align     (align),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_len   (sym_len),
        .sym_data  (sym_data),
        .err       (err),
        .sym_count (sym_count),
        .bit_count (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-bit buffer: LSB is the oldest bit, full once another word would not fit.
    logic [31:0] bstore_q, bstore_d;
    int unsigned bsize_q, bsize_d;

    always_comb begin
        bstore_d = bstore_q >> buf_pop;
        bsize_d  = bsize_q - 32'(buf_pop);
        if (buf_push) begin
            bstore_d = bstore_d | (32'(buf_d) << bsize_d);
            bsize_d  = bsize_d + 8;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            bstore_q <= '0;
            bsize_q  <= 0;
        end else begin
            bstore_q <= bstore_d;
            bsize_q  <= bsize_d;
        end
    end

    assign buf_q    = bstore_q[7:0];
    assign buf_size = 5'(bsize_q);
    assign buf_full = (bsize_q > 8);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, iv, al, rdy, chk;
        logic [7:0]  id;
        logic        e_irdy, e_sv;
        logic [3:0]  e_pop, e_dat;
        logic [2:0]  e_len;
        logic [15:0] e_bc, e_sc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [7:0] id, input logic al,
                       input logic rdy, input logic irdy, input logic [3:0] pop, input logic sv,
                       input logic [2:0] len, input logic [3:0] dat, input logic [15:0] bc,
                       input logic [15:0] sc);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.al = al; v.rdy = rdy; v.chk = !r;
        v.e_irdy = irdy; v.e_pop = pop; v.e_sv = sv; v.e_len = len; v.e_dat = dat;
        v.e_bc = bc; v.e_sc = sc;
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic iv, input logic [7:0] id, input logic al, input logic rdy);
        @(negedge clk);
        in_valid = iv; in_data = id; align = al; sym_ready = rdy;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; align = 1'b0; sym_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst sym_valid", sym_valid, 0);
        check("rst err", err, 0);
        check("rst buf_pop", buf_pop, 0);
        check("rst bit_count", bit_count, 0);
        check("rst sym_count", sym_count, 0);
        check("rst in_ready", in_ready, 1);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          sbits[$];
        logic [7:0]  words[$];
        logic [2:0]  exp_len[$];
        logic [3:0]  exp_dat[$];
        logic [7:0]  w;
        logic [2:0]  prev_len;
        logic [3:0]  prev_dat;
        logic        stalled, saw_full;
        int          widx, got, nsym;
        int unsigned n, p;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; align = 1'b0; sym_ready = 1'b1;

        // rst iv  id     al rdy | irdy pop sv len dat bc  sc
        // Two symbols from 0x0A, consumer always ready.
        add(0, 1, 8'h0A, 0, 1,  1, 0, 0, 0, 0,  0, 0);
        add(0, 0, 8'h00, 0, 1,  1, 5, 0, 0, 0,  0, 0);
        add(0, 0, 8'h00, 0, 1,  1, 3, 1, 2, 1,  5, 0);
        add(0, 0, 8'h00, 0, 1,  1, 0, 1, 0, 0,  8, 1);
        add(0, 0, 8'h00, 0, 1,  1, 0, 0, 0, 0,  8, 2);
        // Back-pressure: slot held stable, no pops, then drains one per cycle.
        add(0, 1, 8'h0A, 0, 0,  1, 0, 0, 0, 0,  8, 2);
        add(0, 0, 8'h00, 0, 0,  1, 5, 0, 0, 0,  8, 2);
        add(0, 0, 8'h00, 0, 0,  1, 0, 1, 2, 1, 13, 2);
        add(0, 0, 8'h00, 0, 0,  1, 0, 1, 2, 1, 13, 2);
        add(0, 0, 8'h00, 0, 1,  1, 3, 1, 2, 1, 13, 2);
        add(0, 0, 8'h00, 0, 1,  1, 0, 1, 0, 0, 16, 3);
        add(0, 0, 8'h00, 0, 1,  1, 0, 0, 0, 0, 16, 4);
        // Align with the slot full: the 3 leftover bits are discarded to the boundary.
        add(0, 1, 8'h0A, 0, 0,  1, 0, 0, 0, 0, 16, 4);
        add(0, 0, 8'h00, 1, 0,  1, 5, 0, 0, 0, 16, 4);
        add(0, 0, 8'h00, 0, 0,  1, 0, 1, 2, 1, 21, 4);
        add(0, 0, 8'h00, 0, 0,  1, 3, 1, 2, 1, 21, 4);
        add(0, 0, 8'h00, 0, 0,  1, 0, 1, 2, 1, 24, 4);
        add(0, 1, 8'h1C, 0, 1,  1, 0, 1, 2, 1, 24, 4);
        add(0, 0, 8'h00, 0, 1,  1, 7, 0, 0, 0, 24, 5);
        add(0, 0, 8'h00, 0, 1,  1, 0, 1, 4, 3, 31, 5);
        add(0, 0, 8'h00, 0, 1,  1, 0, 0, 0, 0, 31, 6);
        // Partial header waits across idle cycles until the next word completes it.
        add(1, 0, 8'h00, 0, 1,  1, 0, 0, 0, 0,  0, 0);
        add(0, 1, 8'h9C, 0, 1,  1, 0, 0, 0, 0,  0, 0);
        add(0, 0, 8'h00, 0, 1,  1, 7, 0, 0, 0,  0, 0);
        add(0, 0, 8'h00, 0, 1,  1, 0, 1, 4, 3,  7, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 0, 1,  1, 0, 0, 0, 0,  7, 1);
        add(0, 1, 8'h00, 0, 1,  1, 0, 0, 0, 0,  7, 1);
        add(0, 0, 8'h00, 0, 1,  0, 4, 0, 0, 0,  7, 1);
        add(0, 0, 8'h00, 0, 1,  1, 3, 1, 1, 0, 11, 1);
        add(0, 0, 8'h00, 0, 1,  1, 0, 1, 0, 0, 14, 2);

        do_reset();

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].id;
            align = vecs[i].al; sym_ready = vecs[i].rdy;
            #2;
            if (vecs[i].chk) begin
                check($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_irdy);
                check($sformatf("v%0d buf_pop", i), buf_pop, vecs[i].e_pop);
                check($sformatf("v%0d sym_valid", i), sym_valid, vecs[i].e_sv);
                check($sformatf("v%0d err", i), err, 0);
                check($sformatf("v%0d bit_count", i), bit_count, vecs[i].e_bc);
                check($sformatf("v%0d sym_count", i), sym_count, vecs[i].e_sc);
                if (vecs[i].e_sv) begin
                    check($sformatf("v%0d sym_len", i), sym_len, vecs[i].e_len);
                    check($sformatf("v%0d sym_data", i), sym_data, vecs[i].e_dat);
                end
            end
        end

        // Bad header: sticky error, no pops, pushes still accepted, align dropped, rst clears.
        do_reset();
        cyc(1, 8'h0A, 0, 1);
        repeat (4) cyc(0, 8'h00, 0, 1);
        check("err pre bit_count", bit_count, 8);
        check("err pre sym_count", sym_count, 2);
        cyc(1, 8'h07, 0, 1);
        check("err before bad", err, 0);
        cyc(0, 8'h00, 0, 1);
        check("err bad pop", buf_pop, 0);
        cyc(1, 8'h0A, 1, 1);
        check("err set", err, 1);
        check("err pop", buf_pop, 0);
        check("err push ready", in_ready, 1);
        cyc(1, 8'h0A, 0, 1);
        check("err full", in_ready, 0);
        check("err pop2", buf_pop, 0);
        check("err sticky", err, 1);
        cyc(0, 8'h00, 0, 1);
        check("err no align pop", buf_pop, 0);
        check("err bit_count held", bit_count, 8);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        check("err rst err", err, 0);
        check("err rst bit_count", bit_count, 0);
        check("err rst sym_count", sym_count, 0);
        rst = 1'b0;

        // Streaming against a reference bitstream with random back-pressure.
        do_reset();
        nsym = 40;
        for (int s = 0; s < nsym; s++) begin
            n = $urandom_range(0, 4);
            p = $urandom_range(0, (1 << n) - 1);
            exp_len.push_back(3'(n));
            exp_dat.push_back(4'(p));
            for (int b = 0; b < 3; b++) sbits.push_back(n[b]);
            for (int b = 0; b < int'(n); b++) sbits.push_back(p[b]);
        end
        while (sbits.size() % 8 != 0) sbits.push_back(1'b0);
        for (int k = 0; k < sbits.size(); k += 8) begin
            for (int b = 0; b < 8; b++) w[b] = sbits[k + b];
            words.push_back(w);
        end

        widx = 0; got = 0; stalled = 1'b0; saw_full = 1'b0;
        prev_len = '0; prev_dat = '0;
        for (int c = 0; c < 3000 && got < nsym; c++) begin
            @(negedge clk);
            in_valid  = (widx < words.size());
            in_data   = in_valid ? words[widx] : 8'h00;
            sym_ready = ($urandom_range(0, 3) != 0);
            #2;
            if (buf_full) saw_full = 1'b1;
            check("stream in_ready", in_ready, !buf_full);
            check("stream pop<=size", 32'(buf_pop) <= 32'(buf_size), 1);
            if (stalled) begin
                check("stream hold len", sym_len, prev_len);
                check("stream hold data", sym_data, prev_dat);
            end
            if (sym_valid && sym_ready) begin
                check($sformatf("stream sym%0d len", got), sym_len, exp_len[got]);
                check($sformatf("stream sym%0d data", got), sym_data, exp_dat[got]);
                got++;
            end
            stalled  = sym_valid && !sym_ready;
            prev_len = sym_len;
            prev_dat = sym_data;
            if (in_valid && in_ready) widx++;
        end
        check("stream symbols received", got, nsym);
        check("stream buffer reached full", saw_full, 1);
        check("stream err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
